// File: rtl/ula_pkg.sv
// Op codes and FSM state encoding shared by the ULA and the decode stage.
package ula_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2
    } state_t;

endpackage

// File: rtl/ula_comb.sv
// Combinational single-cycle ALU ops; MUL/DIVU/REMU are legal here but resolved by the caller.
module ula_comb
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);

    logic [SHW-1:0] shamt;
    logic           slt;
    logic           sltu;

    assign shamt = b[SHW-1:0];
    assign slt   = $signed(a) < $signed(b);
    assign sltu  = a < b;

    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, slt};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, sltu};
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $unsigned($signed(a) >>> shamt);
            OP_MUL, OP_DIVU, OP_REMU: y = '0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Execute-stage ALU: single-cycle ops via ula_comb, iterative shift-add MUL and restoring DIVU/REMU.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Iniciar,
    input  logic [WIDTH-1:0] EntradaA,
    input  logic [WIDTH-1:0] EntradaB,
    input  logic [3:0]       ControleULA,
    input  logic             Cancelar,
    output logic             Pronto,
    output logic             Valido,
    output logic [WIDTH-1:0] Resultado,
    output logic             Zero,
    output logic             Erro
);

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // MUL partial product / DIV partial remainder
    logic [WIDTH-1:0] opa_q, opa_d;   // MUL multiplicand / DIV dividend-then-quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // MUL multiplier / DIV divisor
    logic             is_rem_q, is_rem_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] comb_y;
    logic             comb_illegal;

    ula_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
        .a       (EntradaA),
        .b       (EntradaB),
        .op      (ControleULA),
        .y       (comb_y),
        .illegal (comb_illegal)
    );

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
    assign div_shift = {acc_q, opa_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo   = {opa_q[WIDTH-2:0], div_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= OCIOSO;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            is_rem_q <= 1'b0;
            res_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            is_rem_q <= is_rem_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        is_rem_d = is_rem_q;
        res_d    = res_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        case (state_q)
            OCIOSO: begin
                if (Iniciar && !Cancelar) begin
                    if (ControleULA == OP_MUL) begin
                        state_d = MUL;
                        cnt_d   = SHW'(WIDTH - 1);
                        acc_d   = '0;
                        opa_d   = EntradaA;
                        opb_d   = EntradaB;
                    end else if ((ControleULA == OP_DIVU || ControleULA == OP_REMU)
                                 && EntradaB != '0) begin
                        state_d  = DIV;
                        cnt_d    = SHW'(WIDTH - 1);
                        acc_d    = '0;
                        opa_d    = EntradaA;
                        opb_d    = EntradaB;
                        is_rem_d = (ControleULA == OP_REMU);
                    end else begin
                        // Divide by zero resolves here without entering DIV
                        valid_d = 1'b1;
                        err_d   = comb_illegal;
                        if (ControleULA == OP_DIVU)
                            res_d = '1;
                        else if (ControleULA == OP_REMU)
                            res_d = EntradaA;
                        else
                            res_d = comb_y;
                    end
                end
            end
            MUL: begin
                if (Cancelar) begin
                    state_d = OCIOSO;
                end else begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        state_d = OCIOSO;
                        res_d   = mul_acc;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                    end
                end
            end
            DIV: begin
                if (Cancelar) begin
                    state_d = OCIOSO;
                end else begin
                    acc_d = div_rem;
                    opa_d = div_quo;
                    cnt_d = cnt_q - SHW'(1);
                    if (cnt_q == '0) begin
                        state_d = OCIOSO;
                        res_d   = is_rem_q ? div_rem : div_quo;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                    end
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    assign Pronto    = (state_q == OCIOSO);
    assign Valido    = valid_q;
    assign Resultado = res_q;
    assign Zero      = (res_q == '0);
    assign Erro      = err_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo at WIDTH=32 and WIDTH=8.
module tb_ula_multiciclo;
    import ula_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Iniciar = 1'b0;
    logic [31:0] EntradaA = '0;
    logic [31:0] EntradaB = '0;
    logic [3:0]  ControleULA = '0;
    logic        Cancelar = 1'b0;
    logic        Pronto, Valido, Zero, Erro;
    logic [31:0] Resultado;

    logic        ini8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [3:0]  op8 = '0;
    logic        canc8 = 1'b0;
    logic        pronto8, valido8, zero8, erro8;
    logic [7:0]  res8;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t q8[$];

    ula_multiciclo #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .Iniciar(Iniciar), .EntradaA(EntradaA),
        .EntradaB(EntradaB), .ControleULA(ControleULA), .Cancelar(Cancelar),
        .Pronto(Pronto), .Valido(Valido), .Resultado(Resultado), .Zero(Zero), .Erro(Erro)
    );

    ula_multiciclo #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .Iniciar(ini8), .EntradaA(a8),
        .EntradaB(b8), .ControleULA(op8), .Cancelar(canc8),
        .Pronto(pronto8), .Valido(valido8), .Resultado(res8), .Zero(zero8), .Erro(erro8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && Valido) begin
            if (q.size() == 0) begin
                chk("unexpected_valido32", 64'(Resultado), 64'hDEAD_BEEF_0000_0000);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resultado32", 64'(Resultado), 64'(e.res));
                chk("erro32", 64'(Erro), 64'(e.err));
                chk("zero32", 64'(Zero), 64'(e.res == 32'd0));
                chk("latency32", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && valido8) begin
            if (q8.size() == 0) begin
                chk("unexpected_valido8", 64'(res8), 64'hDEAD_BEEF_0000_0000);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("resultado8", 64'(res8), 64'(e.res[7:0]));
                chk("erro8", 64'(erro8), 64'(e.err));
                chk("latency8", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one request for a cycle; optionally register the expected response.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic err, input int lat, input bit push);
        exp_t e;
        Iniciar     = 1'b1;
        ControleULA = op;
        EntradaA    = a;
        EntradaB    = b;
        e.res = res;
        e.err = err;
        e.cyc = cyc + 1 + lat;
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!Pronto && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(Pronto), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_pronto", 64'(Pronto), 64'd1);
        chk("rst_valido", 64'(Valido), 64'd0);
        chk("rst_resultado", 64'(Resultado), 64'd0);
        chk("rst_zero", 64'(Zero), 64'd1);
        chk("rst_erro", 64'(Erro), 64'd0);
        @(negedge clk);

        // Back-to-back single-cycle ops, Iniciar held for four cycles
        issue(OP_ADD, 32'd7, 32'd5, 32'd12, 1'b0, 0, 1'b1);
        chk("b2b_pronto0", 64'(Pronto), 64'd1);
        issue(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);
        chk("b2b_pronto1", 64'(Pronto), 64'd1);
        issue(OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0, 1'b1);
        chk("b2b_pronto2", 64'(Pronto), 64'd1);
        issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1);
        chk("b2b_pronto3", 64'(Pronto), 64'd1);
        Iniciar = 1'b0;
        @(negedge clk);

        // Multi-cycle ops; operand changes while busy must not matter
        issue(OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 32, 1'b1);
        Iniciar = 1'b1; EntradaA = 32'h1234_5678; EntradaB = '1; ControleULA = OP_AND;
        chk("mul_busy", 64'(Pronto), 64'd0);
        wait_ready();
        Iniciar = 1'b0;
        @(negedge clk);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 32, 1'b1);
        Iniciar = 1'b0;
        wait_ready();
        @(negedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 32, 1'b1);
        Iniciar = 1'b0;
        chk("div_busy", 64'(Pronto), 64'd0);
        wait_ready();
        @(negedge clk);
        issue(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 32, 1'b1);
        Iniciar = 1'b0;
        wait_ready();
        @(negedge clk);
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 32, 1'b1);
        Iniciar = 1'b0;
        wait_ready();
        @(negedge clk);

        // Divide by zero fast path
        issue(OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
        issue(OP_REMU, 32'd9, 32'd0, 32'd9, 1'b0, 0, 1'b1);
        Iniciar = 1'b0;
        @(negedge clk);

        // Flush a DIVU mid-flight; Resultado must hold 9
        issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 0, 1'b0);
        Iniciar = 1'b0;
        repeat (8) @(negedge clk);
        Cancelar = 1'b1;
        @(negedge clk);
        Cancelar = 1'b0;
        chk("cancel_pronto", 64'(Pronto), 64'd1);
        chk("cancel_valido", 64'(Valido), 64'd0);
        chk("cancel_hold", 64'(Resultado), 64'd9);
        repeat (40) @(negedge clk);

        // Cancelar in idle blocks acceptance
        Cancelar = 1'b1;
        issue(OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 0, 1'b0);
        Cancelar = 1'b0;
        Iniciar  = 1'b0;
        chk("cancel_idle_valido", 64'(Valido), 64'd0);
        chk("cancel_idle_hold", 64'(Resultado), 64'd9);
        @(negedge clk);
        issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b1);

        // Illegal op then a legal AND
        issue(4'b0100, 32'd5, 32'd6, 32'd0, 1'b1, 0, 1'b1);
        issue(OP_AND, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, 0, 1'b1);
        Iniciar = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a MUL
        issue(OP_MUL, 32'd3, 32'd3, 32'd0, 1'b0, 0, 1'b0);
        Iniciar = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("amid_rst_resultado", 64'(Resultado), 64'd0);
        chk("amid_rst_pronto", 64'(Pronto), 64'd1);
        chk("amid_rst_valido", 64'(Valido), 64'd0);
        chk("amid_rst_zero", 64'(Zero), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // WIDTH=8 instance
        begin
            exp_t e;
            int n;
            ini8 = 1'b1; op8 = OP_MUL; a8 = 8'd13; b8 = 8'd11;
            e.res = 32'h8F; e.err = 1'b0; e.cyc = cyc + 1 + 8;
            q8.push_back(e);
            @(negedge clk);
            ini8 = 1'b0;
            chk("mul8_busy", 64'(pronto8), 64'd0);
            n = 0;
            while (!pronto8 && n < 100) begin @(negedge clk); n++; end
            chk("ready8_timeout", 64'(pronto8), 64'd1);
            @(negedge clk);
            ini8 = 1'b1; op8 = OP_DIVU; a8 = 8'd200; b8 = 8'd7;
            e.res = 32'd28; e.err = 1'b0; e.cyc = cyc + 1 + 8;
            q8.push_back(e);
            @(negedge clk);
            ini8 = 1'b0;
            n = 0;
            while (!pronto8 && n < 100) begin @(negedge clk); n++; end
            chk("ready8_timeout2", 64'(pronto8), 64'd1);
        end

        repeat (5) @(negedge clk);
        chk("q32_drained", 64'(q.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
